// File: rtl/iter_shift_ctrl_if.sv
// iter_shift_ctrl_if: start/done handshake bundle for iter_shift_ctrl; ITER_SHIFT_ARITH_EN adds arith
interface iter_shift_ctrl_if #(
  parameter int n   = 32,
  parameter int SHW = 5
);
  logic           start;
  logic [n-1:0]   num;
  logic [SHW-1:0] shamt;
  logic           dir;
`ifdef ITER_SHIFT_ARITH_EN
  logic           arith;
`endif
  logic           busy;
  logic           done;
  logic [n-1:0]   result;
  logic           lost;
`ifdef ITER_SHIFT_ARITH_EN
  modport master (output start, num, shamt, dir, arith, input busy, done, result, lost);
  modport slave  (input start, num, shamt, dir, arith, output busy, done, result, lost);
`else
  modport master (output start, num, shamt, dir, input busy, done, result, lost);
  modport slave  (input start, num, shamt, dir, output busy, done, result, lost);
`endif
endinterface

// File: rtl/iter_shift_ctrl.sv
// iter_shift_ctrl: multi-cycle logical shifter stepping by 2 (plus a 1-bit tail); ITER_SHIFT_ARITH_EN enables arithmetic right shift
module iter_shift_ctrl #(
  parameter int n   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  iter_shift_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t         state, state_nx;
  logic [n-1:0]   acc, sh, result;
  logic [SHW-1:0] rem, rem_nx;
  logic           sticky, dir_q, fill, two, shout, lost, accept;
  assign accept = (state == IDLE) && bus.start;
  assign two    = rem > SHW'(1);
  assign rem_nx = two ? rem - SHW'(2) : '0;
`ifdef ITER_SHIFT_ARITH_EN
  logic arith_q;
  // capture arith alongside the other operands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) arith_q <= 1'b0;
    else if (accept) arith_q <= bus.arith;
  assign fill = dir_q & arith_q & acc[n-1];
`else
  assign fill = 1'b0;
`endif
  // one shifter step: by 2 while rem >= 2, else by 1; shout collects bits leaving the word
  always_comb begin
    sh    = dir_q ? (two ? {{2{fill}}, acc[n-1:2]} : {fill, acc[n-1:1]})
                  : (two ? {acc[n-3:0], 2'b00} : {acc[n-2:0], 1'b0});
    shout = dir_q ? (two ? |acc[1:0] : acc[0]) : (two ? |acc[n-1:n-2] : acc[n-1]);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state logic; start is only honoured in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_nx == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: load on accept, step in SHIFT, publish result/lost on entry to DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc    <= '0;
      rem    <= '0;
      sticky <= 1'b0;
      dir_q  <= 1'b0;
      result <= '0;
      lost   <= 1'b0;
    end else if (accept) begin
      if (bus.shamt == '0) begin
        result <= bus.num;
        lost   <= 1'b0;
      end else begin
        acc    <= bus.num;
        rem    <= bus.shamt;
        dir_q  <= bus.dir;
        sticky <= 1'b0;
      end
    end else if (state == SHIFT) begin
      acc    <= sh;
      rem    <= rem_nx;
      sticky <= sticky | shout;
      if (rem_nx == '0) begin
        result <= sh;
        lost   <= sticky | shout;
      end
    end
  assign bus.busy   = state != IDLE;
  assign bus.done   = state == DONE;
  assign bus.result = result;
  assign bus.lost   = lost;
endmodule

// File: tb/tb_iter_shift_ctrl.sv
// tb_iter_shift_ctrl: table-driven check of iter_shift_ctrl plus ignored-start and mid-operation reset sequences
module tb_iter_shift_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  iter_shift_ctrl_if #(.n(32), .SHW(5)) bus ();
  iter_shift_ctrl #(.n(32), .SHW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic [4:0]  shamt;
    logic        dir;
    logic        arith;
    logic [31:0] res;
    logic        lost;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic d, input logic ar,
                        output logic [31:0] res, output logic l, output int lat, output int bz);
    @(negedge clk);
    bus.start = 1'b1;
    bus.num = a;
    bus.shamt = s;
    bus.dir = d;
`ifdef ITER_SHIFT_ARITH_EN
    bus.arith = ar;
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.num = ~a;
    bus.shamt = ~s;
    bus.dir = ~d;
`ifdef ITER_SHIFT_ARITH_EN
    bus.arith = ~ar;
`endif
    lat = 0;
    bz = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.busy) bz++;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    res = bus.result;
    l = bus.lost;
  endtask

  vec_t tbl[8];
  logic [31:0] r;
  logic lo;
  int lat, bz, seen;

  initial begin
    tbl[0] = '{32'h0000BEEF, 5'd2,  1'b0, 1'b0, 32'h0002FBBC, 1'b0, 2};
    tbl[1] = '{32'hFFFFFFFF, 5'd5,  1'b0, 1'b0, 32'hFFFFFFE0, 1'b1, 4};
    tbl[2] = '{32'h13579BDF, 5'd0,  1'b0, 1'b0, 32'h13579BDF, 1'b0, 1};
    tbl[3] = '{32'hF0000000, 5'd31, 1'b1, 1'b0, 32'h00000001, 1'b1, 17};
    tbl[4] = '{32'h80000001, 5'd1,  1'b1, 1'b0, 32'h40000000, 1'b1, 2};
    tbl[5] = '{32'h80000001, 5'd1,  1'b0, 1'b0, 32'h00000002, 1'b1, 2};
    tbl[6] = '{32'h0000000C, 5'd2,  1'b1, 1'b0, 32'h00000003, 1'b0, 2};
    tbl[7] = '{32'h12345678, 5'd4,  1'b1, 1'b0, 32'h01234567, 1'b1, 3};
    bus.start = 1'b0;
    bus.num = '0;
    bus.shamt = '0;
    bus.dir = 1'b0;
`ifdef ITER_SHIFT_ARITH_EN
    bus.arith = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_lost", {31'b0, bus.lost}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].num, tbl[i].shamt, tbl[i].dir, tbl[i].arith, r, lo, lat, bz);
      chk($sformatf("v%0d_result", i), r, tbl[i].res);
      chk($sformatf("v%0d_lost", i), {31'b0, lo}, {31'b0, tbl[i].lost});
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bz, tbl[i].lat);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {30'b0, bus.done, bus.busy}, 32'd0);
      chk($sformatf("v%0d_result_hold", i), bus.result, tbl[i].res);
    end
`ifdef ITER_SHIFT_ARITH_EN
    run_op(32'hF0000000, 5'd4, 1'b1, 1'b1, r, lo, lat, bz);
    chk("arith_result", r, 32'hFF000000);
    chk("arith_lost", {31'b0, lo}, 32'd0);
    run_op(32'hF0000000, 5'd4, 1'b1, 1'b0, r, lo, lat, bz);
    chk("logic_result", r, 32'h0F000000);
    run_op(32'hF0000001, 5'd4, 1'b0, 1'b1, r, lo, lat, bz);
    chk("arith_left_result", r, 32'h00000010);
`endif
    // second start while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.num = 32'h00000001;
    bus.shamt = 5'd8;
    bus.dir = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) chk("ign_result_held", bus.result, tbl[7].res);
      if (c == 2) begin
        bus.start = 1'b1;
        bus.num = 32'hFFFFFFFF;
        bus.shamt = 5'd3;
      end
      if (c == 3) bus.start = 1'b0;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    chk("ign_latency", lat, 5);
    chk("ign_result", bus.result, 32'h00000100);
    chk("ign_lost", {31'b0, bus.lost}, 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("ign_no_second_op", {31'b0, bus.busy}, 32'd0);
    // reset in the middle of an operation
    bus.start = 1'b1;
    bus.num = 32'h00000001;
    bus.shamt = 5'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_lost", {31'b0, bus.lost}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("rst_no_done", seen, 0);
    run_op(32'h0000BEEF, 5'd2, 1'b0, 1'b0, r, lo, lat, bz);
    chk("post_rst_result", r, 32'h0002FBBC);
    chk("post_rst_latency", lat, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iter_shift_ctrl.md
Name: iter_shift_ctrl

Overview:
Multi-cycle shift controller that sequences a shift-by-2 datapath stage, plus a shift-by-1 tail step, to perform an arbitrary 0..n-1 bit logical shift.
- Shares one small shifter stage across cycles instead of building a full barrel shifter.
- Sits beside the ALU and is driven by a start/done handshake from the control unit for sll/srl-class instructions.
- Flags whether any 1 bits were shifted out.

Parameters:
n, 32, data width in bits
SHW, 5, shift-amount width; must satisfy 2**SHW >= n

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
num  input  n  operand; captured when start is accepted
shamt  input  SHW  shift amount; captured when start is accepted
dir  input  1  0 = shift left, 1 = shift right (logical); captured when start is accepted
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: result and lost are valid and updated this cycle
result  output  n  registered shifted value; holds until the next done
lost  output  1  registered; 1 if any 1 bit was shifted out of the word

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset, asserted at any time including mid-operation:
  - state = IDLE;
  - acc, rem, result and sticky are all 0;
  - busy = 0, done = 0, result = 0, lost = 0.
  - Any operation in flight is discarded; no done is produced for it.
- Internal registers: acc[n-1:0], rem[SHW-1:0], sticky (1 bit), dir_q (1 bit).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 0: stay in IDLE.
  - start = 1 and shamt = 0: result <= num, lost <= 0, go to DONE.
  - start = 1 and shamt != 0: acc <= num, rem <= shamt, dir_q <= dir, sticky <= 0, go to SHIFT.
- SHIFT, one step per cycle:
  - rem >= 2: shift acc by 2 in direction dir_q, zero fill; rem <= rem - 2.
  - rem = 1: shift acc by 1, zero fill; rem <= 0.
  - sticky <= sticky OR (OR of the bits shifted out this step).
  - Bits shifted out of a left shift are acc[n-1:n-k]; of a right shift, acc[k-1:0]; k = step size.
  - If the new rem = 0: result <= shifted acc, lost <= new sticky, go to DONE. Otherwise stay in SHIFT.
- DONE: done = 1 for exactly this cycle; go to IDLE unconditionally. start is ignored in DONE.
- start in SHIFT or DONE is ignored. No queuing; the requester must wait for done and then re-issue in IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0 + ceil(shamt/2). That is 1 cycle for shamt = 0 and 17 cycles for shamt = 31.
- busy is high from the cycle after acceptance through the DONE cycle inclusive.
- num, shamt and dir may change freely after acceptance without effect.
- shamt >= n (possible only if 2**SHW > n): result = 0 and lost = OR(num). The step loop produces this naturally.
- result and lost change only on entry to DONE or on reset.

Optional Feature:
ITER_SHIFT_ARITH_EN
- Defined: adds input port arith (1 bit), captured when start is accepted. When dir = 1 and arith = 1, each step fills vacated MSBs with acc[n-1] (arithmetic right shift). lost is still the OR of the bits shifted out. arith is ignored when dir = 0.
- Undefined: the arith port does not exist; all shifts zero-fill.

Test Plan:
- num = 0x0000BEEF, shamt = 2, dir = 0 -> done 2 cycles after start; result = 0x0002FBBC, lost = 0; busy high for 2 cycles.
- num = 0xFFFFFFFF, shamt = 5, dir = 0 -> done 4 cycles after start; result = 0xFFFFFFE0, lost = 1.
- num = 0x13579BDF, shamt = 0 -> done 1 cycle after start; result = 0x13579BDF, lost = 0.
- num = 0xF0000000, shamt = 31, dir = 1 -> done 17 cycles after start; result = 0x00000001, lost = 1.
- Start num = 0x00000001, shamt = 8, dir = 0. Pulse start again with num = 0xFFFFFFFF at cycle 2 -> second start ignored; result = 0x00000100. Then rerun and pull rst_n low at cycle 3 -> busy, done, result and lost are 0 immediately; no done follows; a fresh start works normally.
- With ITER_SHIFT_ARITH_EN defined: num = 0xF0000000, shamt = 4, dir = 1, arith = 1 -> result = 0xFF000000, lost = 0. Same inputs with arith = 0 -> result = 0x0F000000.
